// File: rtl/matrix_tile_sequencer.sv
// Walks a rows x cols matrix in row-major TILE x TILE tiles, presenting per-lane
// addresses, in-bounds mask and write strobes for one tile at a time.
module matrix_tile_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int TILE       = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         wr_mode,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH-1:0]        rows,
    input  logic [ADDR_WIDTH-1:0]        cols,
    input  logic [ADDR_WIDTH-1:0]        stride,
    input  logic                         advance,
    output logic                         busy,
    output logic                         tile_valid,
    output logic [ADDR_WIDTH-1:0]        tile_row,
    output logic [ADDR_WIDTH-1:0]        tile_col,
    output logic [TILE*TILE*ADDR_WIDTH-1:0] addr_flat,
    output logic [TILE*TILE-1:0]         lane_mask,
    output logic [TILE*TILE-1:0]         lane_we,
    output logic                         last_tile,
    output logic                         done
);

    localparam int DW = ADDR_WIDTH + 1;

    // Handshake: a tile is offered while tile_valid=1 and is consumed on any
    // cycle where advance=1; outputs hold unchanged until then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                  load_cfg;
    logic                  step_tile;
    logic                  cfg_wr_mode;
    logic [ADDR_WIDTH-1:0] cfg_rows;
    logic [ADDR_WIDTH-1:0] cfg_cols;
    logic [ADDR_WIDTH-1:0] cfg_stride;
    logic [ADDR_WIDTH-1:0] row_step;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [DW-1:0]         next_row_w;
    logic [DW-1:0]         next_col_w;
    logic                  col_wrap;
    logic                  row_end;
    logic [ADDR_WIDTH-1:0] lane_base;
    logic                  row_in;
    logic                  col_in;

    // Extra bit keeps tile_row/col + TILE from wrapping in the end checks.
    assign next_col_w = {1'b0, tile_col} + DW'(TILE);
    assign next_row_w = {1'b0, tile_row} + DW'(TILE);
    assign col_wrap   = next_col_w >= {1'b0, cfg_cols};
    assign row_end    = next_row_w >= {1'b0, cfg_rows};

    assign tile_valid = (state == RUN);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign last_tile  = (state == RUN) && row_end && col_wrap;
    assign lane_we    = (tile_valid && advance && cfg_wr_mode) ? lane_mask : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_cfg   = 1'b0;
        step_tile  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_cfg   = 1'b1;
                    state_next = (rows == '0 || cols == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (advance) begin
                    if (last_tile) begin
                        state_next = DONE;
                    end else begin
                        step_tile = 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // row_base tracks base + tile_row*stride incrementally, stepping by TILE*stride.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_wr_mode <= 1'b0;
            cfg_rows    <= '0;
            cfg_cols    <= '0;
            cfg_stride  <= '0;
            row_step    <= '0;
            row_base    <= '0;
            tile_row    <= '0;
            tile_col    <= '0;
        end else if (load_cfg) begin
            cfg_wr_mode <= wr_mode;
            cfg_rows    <= rows;
            cfg_cols    <= cols;
            cfg_stride  <= stride;
            row_step    <= ADDR_WIDTH'(stride * ADDR_WIDTH'(TILE));
            row_base    <= base_addr;
            tile_row    <= '0;
            tile_col    <= '0;
        end else if (step_tile) begin
            if (!col_wrap) begin
                tile_col <= tile_col + ADDR_WIDTH'(TILE);
            end else begin
                tile_col <= '0;
                tile_row <= tile_row + ADDR_WIDTH'(TILE);
                row_base <= row_base + row_step;
            end
        end
    end

    // Each tile row's base is the previous one plus stride, so only adders are used.
    always_comb begin
        addr_flat = '0;
        lane_mask = '0;
        lane_base = row_base;
        row_in    = 1'b0;
        col_in    = 1'b0;
        for (int r = 0; r < TILE; r++) begin
            row_in = ({1'b0, tile_row} + DW'(r)) < {1'b0, cfg_rows};
            for (int c = 0; c < TILE; c++) begin
                col_in = ({1'b0, tile_col} + DW'(c)) < {1'b0, cfg_cols};
                if (tile_valid && row_in && col_in) begin
                    lane_mask[r*TILE + c] = 1'b1;
                    addr_flat[(r*TILE + c)*ADDR_WIDTH +: ADDR_WIDTH] =
                        lane_base + tile_col + ADDR_WIDTH'(c);
                end
            end
            lane_base = lane_base + cfg_stride;
        end
    end

endmodule

// File: tb/tb_matrix_tile_sequencer.sv
// Self-checking bench for matrix_tile_sequencer: directed walks from the
// requirements plus randomized walks against an arithmetic tile/address model.
module tb_matrix_tile_sequencer;

    localparam int AW = 10;
    localparam int T  = 3;
    localparam int L  = T*T;

    logic            clk;
    logic            reset;
    logic            start;
    logic            wr_mode;
    logic [AW-1:0]   base_addr;
    logic [AW-1:0]   rows;
    logic [AW-1:0]   cols;
    logic [AW-1:0]   stride;
    logic            advance;
    logic            busy;
    logic            tile_valid;
    logic [AW-1:0]   tile_row;
    logic [AW-1:0]   tile_col;
    logic [L*AW-1:0] addr_flat;
    logic [L-1:0]    lane_mask;
    logic [L-1:0]    lane_we;
    logic            last_tile;
    logic            done;

    // Narrow-address instance for the wrap-around case.
    logic            s4_start;
    logic            s4_wr_mode;
    logic [3:0]      s4_base_addr;
    logic [3:0]      s4_rows;
    logic [3:0]      s4_cols;
    logic [3:0]      s4_stride;
    logic            s4_advance;
    logic            s4_busy;
    logic            s4_tile_valid;
    logic [3:0]      s4_tile_row;
    logic [3:0]      s4_tile_col;
    logic [L*4-1:0]  s4_addr_flat;
    logic [L-1:0]    s4_lane_mask;
    logic [L-1:0]    s4_lane_we;
    logic            s4_last_tile;
    logic            s4_done;

    int total = 0;
    int bad   = 0;
    logic [2*AW-1:0] exp_q[$];

    matrix_tile_sequencer #(.ADDR_WIDTH(AW), .TILE(T)) dut (
        .clk(clk), .reset(reset), .start(start), .wr_mode(wr_mode),
        .base_addr(base_addr), .rows(rows), .cols(cols), .stride(stride),
        .advance(advance), .busy(busy), .tile_valid(tile_valid),
        .tile_row(tile_row), .tile_col(tile_col), .addr_flat(addr_flat),
        .lane_mask(lane_mask), .lane_we(lane_we), .last_tile(last_tile),
        .done(done)
    );

    matrix_tile_sequencer #(.ADDR_WIDTH(4), .TILE(T)) dut4 (
        .clk(clk), .reset(reset), .start(s4_start), .wr_mode(s4_wr_mode),
        .base_addr(s4_base_addr), .rows(s4_rows), .cols(s4_cols), .stride(s4_stride),
        .advance(s4_advance), .busy(s4_busy), .tile_valid(s4_tile_valid),
        .tile_row(s4_tile_row), .tile_col(s4_tile_col), .addr_flat(s4_addr_flat),
        .lane_mask(s4_lane_mask), .lane_we(s4_lane_we), .last_tile(s4_last_tile),
        .done(s4_done)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard compare
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: lane (r,c) of tile (tr,tc) is element (tr+r, tc+c).
    function automatic logic [L-1:0] model_mask(int tr, int tc, int nrows, int ncols);
        logic [L-1:0] m;
        m = '0;
        for (int k = 0; k < L; k++) begin
            if (tr + k / T < nrows && tc + k % T < ncols) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [L*AW-1:0] model_addr(int tr, int tc, int nrows, int ncols,
                                                   int base, int strd);
        logic [L*AW-1:0] v;
        int a;
        v = '0;
        for (int k = 0; k < L; k++) begin
            if (tr + k / T < nrows && tc + k % T < ncols) begin
                a = (base + (tr + k / T) * strd + tc + k % T) % (1 << AW);
                v[k*AW +: AW] = AW'(a);
            end
        end
        return v;
    endfunction

    // Drivers
    task automatic scramble_cfg();
        wr_mode   = 1'($urandom_range(0, 1));
        base_addr = AW'($urandom_range(0, 1023));
        rows      = AW'($urandom_range(0, 1023));
        cols      = AW'($urandom_range(0, 1023));
        stride    = AW'($urandom_range(0, 1023));
    endtask

    task automatic check_tile(int tr, int tc, int nrows, int ncols, int base, int strd, bit last);
        chk("tile_valid", tile_valid, 1);
        chk("busy_run", busy, 1);
        chk("done_run", done, 0);
        chk("tile_row", tile_row, tr);
        chk("tile_col", tile_col, tc);
        chk("last_tile", last_tile, last);
        chk("lane_mask", lane_mask, model_mask(tr, tc, nrows, ncols));
        chk("addr_flat", addr_flat, model_addr(tr, tc, nrows, ncols, base, strd));
        chk("lane_we_hold", lane_we, 0);
    endtask

    task automatic run_walk(int base, int nrows, int ncols, int strd, bit wr,
                            int hold_min, int hold_max, bit poke_start);
        logic [2*AW-1:0] t;
        int tr, tc, hold;
        logic [L-1:0] m;
        exp_q.delete();
        for (int r = 0; r < nrows; r += T)
            for (int c = 0; c < ncols; c += T)
                exp_q.push_back({AW'(r), AW'(c)});
        @(negedge clk);
        start = 1'b1; wr_mode = wr; advance = 1'b0;
        base_addr = AW'(base); rows = AW'(nrows); cols = AW'(ncols); stride = AW'(strd);
        @(negedge clk);
        start = 1'b0;
        scramble_cfg();
        if (exp_q.size() == 0) begin
            #1;
            chk("zero_done", done, 1);
            chk("zero_valid", tile_valid, 0);
            chk("zero_busy", busy, 1);
            @(negedge clk); #1;
            chk("zero_idle_busy", busy, 0);
            chk("zero_idle_done", done, 0);
            chk("zero_idle_valid", tile_valid, 0);
            return;
        end
        while (exp_q.size() > 0) begin
            t  = exp_q.pop_front();
            tr = int'(t[2*AW-1:AW]);
            tc = int'(t[AW-1:0]);
            hold = $urandom_range(hold_min, hold_max);
            for (int h = 0; h <= hold; h++) begin
                if (h > 0) begin
                    @(negedge clk);
                    start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
                    scramble_cfg();
                end
                #1;
                check_tile(tr, tc, nrows, ncols, base, strd, exp_q.size() == 0);
            end
            start = 1'b0;
            advance = 1'b1;
            #1;
            m = model_mask(tr, tc, nrows, ncols);
            chk("lane_we_accept", lane_we, wr ? m : '0);
            @(negedge clk);
            advance = 1'b0;
        end
        #1;
        chk("end_done", done, 1);
        chk("end_valid", tile_valid, 0);
        chk("end_busy", busy, 1);
        chk("end_last", last_tile, 0);
        @(negedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", tile_valid, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; advance = 1'b0;
        wr_mode = 1'b0; base_addr = '0; rows = '0; cols = '0; stride = '0;
        s4_start = 1'b0; s4_advance = 1'b0; s4_wr_mode = 1'b0;
        s4_base_addr = '0; s4_rows = '0; s4_cols = '0; s4_stride = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", tile_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_row", tile_row, 0);
        chk("rst_col", tile_col, 0);
        chk("rst_addr", addr_flat, 0);
        chk("rst_mask", lane_mask, 0);
        chk("rst_we", lane_we, 0);
        chk("rst_last", last_tile, 0);
        reset = 1'b0;

        // Single full tile, then 6x6 in four tiles, then ragged 4x5 edges.
        run_walk(0, 3, 3, 3, 1'b0, 0, 0, 1'b0);
        run_walk(100, 6, 6, 6, 1'b0, 0, 1, 1'b0);
        run_walk(0, 4, 5, 5, 1'b1, 0, 1, 1'b0);
        // Write walk with a long stall and start pokes mid-walk.
        run_walk(37, 5, 7, 9, 1'b1, 5, 5, 1'b1);

        // Reset on the second tile, with start/advance also high.
        @(negedge clk);
        start = 1'b1; wr_mode = 1'b1; base_addr = 10'd100;
        rows = 10'd6; cols = 10'd6; stride = 10'd6;
        @(negedge clk);
        start = 1'b0; advance = 1'b1;
        @(negedge clk);
        advance = 1'b0; #1;
        chk("mid_col", tile_col, 3);
        chk("mid_valid", tile_valid, 1);
        reset = 1'b1; start = 1'b1; advance = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; advance = 1'b0; #1;
        chk("mr_valid", tile_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_col", tile_col, 0);
        chk("mr_mask", lane_mask, 0);
        chk("mr_addr", addr_flat, 0);
        @(negedge clk); #1;
        chk("mr_no_done", done, 0);
        run_walk(100, 6, 6, 6, 1'b0, 0, 0, 1'b0);

        // Degenerate dimensions.
        run_walk(5, 0, 4, 4, 1'b0, 0, 0, 1'b0);
        run_walk(5, 4, 0, 4, 1'b1, 0, 0, 1'b0);

        // Randomized walks including address wrap at 2^AW.
        for (int i = 0; i < 8; i++) begin
            run_walk($urandom_range(0, 1023), $urandom_range(1, 10), $urandom_range(1, 10),
                     $urandom_range(0, 1023), 1'($urandom_range(0, 1)), 0, 2,
                     1'($urandom_range(0, 1)));
        end

        // 4-bit address wrap: lanes 14, 15, 0.
        @(negedge clk);
        s4_start = 1'b1; s4_wr_mode = 1'b1; s4_base_addr = 4'd14;
        s4_rows = 4'd1; s4_cols = 4'd3; s4_stride = 4'd1;
        @(negedge clk);
        s4_start = 1'b0; #1;
        chk("w4_valid", s4_tile_valid, 1);
        chk("w4_addr", s4_addr_flat, 36'h0000000FE);
        chk("w4_mask", s4_lane_mask, 9'h007);
        chk("w4_last", s4_last_tile, 1);
        s4_advance = 1'b1; #1;
        chk("w4_we", s4_lane_we, 9'h007);
        @(negedge clk);
        s4_advance = 1'b0; #1;
        chk("w4_done", s4_done, 1);
        chk("w4_end_valid", s4_tile_valid, 0);
        @(negedge clk); #1;
        chk("w4_idle", s4_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_tile_sequencer.md
MATRIX_TILE_SEQUENCER -- requirements
Module: matrix_tile_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ADDR_WIDTH, 10, memory address and dimension width
  TILE, 3, tile edge length; each tile has TILE*TILE lanes
REQ-002 Ports SHALL be, one per line (name direction width meaning):
  clk  input  1  single clock; all state updates on posedge
  reset  input  1  synchronous, active-high reset
  start  input  1  request a matrix walk; sampled only in IDLE
  wr_mode  input  1  1 = walk writes memory, 0 = walk reads; latched on start
  base_addr  input  ADDR_WIDTH  address of element (0,0); latched on start
  rows  input  ADDR_WIDTH  matrix row count; latched on start
  cols  input  ADDR_WIDTH  matrix column count; latched on start
  stride  input  ADDR_WIDTH  words between vertically adjacent elements; latched on start
  advance  input  1  consumer accepts the current tile
  busy  output  1  walk in progress (RUN or DONE state)
  tile_valid  output  1  addr_flat/lane_mask describe a valid tile
  tile_row  output  ADDR_WIDTH  matrix row of the tile's top-left lane
  tile_col  output  ADDR_WIDTH  matrix column of the tile's top-left lane
  addr_flat  output  TILE*TILE*ADDR_WIDTH  lane k address at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
  lane_mask  output  TILE*TILE  bit k = 1 when lane k is inside the matrix
  lane_we  output  TILE*TILE  per-lane memory write strobe
  last_tile  output  1  current tile is the final tile of the walk
  done  output  1  one-cycle pulse at walk completion

Function
REQ-003 Lane k SHALL map to tile offset r = k / TILE, c = k % TILE.
REQ-004 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-005 In IDLE with start=1 and rows!=0 and cols!=0, the block SHALL latch all configuration inputs, set tile_row=tile_col=0, and enter RUN; tile_valid SHALL be 1 on the following cycle.
REQ-006 In IDLE with start=1 and rows==0 or cols==0, the block SHALL enter DONE directly; tile_valid SHALL never assert for that walk.
REQ-007 start SHALL be ignored in RUN and DONE, and configuration inputs SHALL be ignored outside the start-acceptance cycle.
REQ-008 In RUN, tile_valid SHALL be 1 and busy SHALL be 1; tile outputs SHALL hold stable while advance=0.
REQ-009 On advance=1 in RUN with last_tile=0: if tile_col+TILE < cols then tile_col += TILE, else tile_col = 0 and tile_row += TILE (row-major tile order).
REQ-010 On advance=1 in RUN with last_tile=1, the FSM SHALL enter DONE.
REQ-011 last_tile SHALL equal (tile_row+TILE >= rows) and (tile_col+TILE >= cols) while in RUN, and 0 otherwise.
REQ-012 In DONE, done SHALL be 1, tile_valid 0, and busy 1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-013 Lane address SHALL be base_addr + (tile_row+r)*stride + tile_col + c, truncated modulo 2^ADDR_WIDTH.
REQ-014 A registered row-base (base_addr + tile_row*stride) SHALL be kept, incremented by TILE*stride on each row step; no multiplier by tile_row SHALL be used.
REQ-015 lane_mask bit k SHALL be 1 iff tile_valid and tile_row+r < rows and tile_col+c < cols; masked-off lanes SHALL drive address 0.
REQ-016 lane_we SHALL equal lane_mask when tile_valid, advance and the latched wr_mode are all 1, and 0 otherwise.
REQ-017 No output SHALL have a combinational path from start; lane_we is the only output combinationally dependent on advance.

Reset
REQ-018 With reset=1 at a clock edge, the FSM SHALL enter IDLE and all outputs and internal registers SHALL be 0 the following cycle, regardless of state.
REQ-019 reset SHALL take priority over start and advance in the same cycle; a reset mid-walk SHALL abandon it without a done pulse.

Verification
REQ-020 TILE=3, base=0, rows=3, cols=3, stride=3, start -> next cycle tile_valid=1, lane addresses 0..8, lane_mask=0x1FF, last_tile=1; advance -> done=1 next cycle, then IDLE.
REQ-021 base=100, rows=6, cols=6, stride=6 -> tiles (0,0),(0,3),(3,0),(3,3); tile (0,3) lanes = 103,104,105,109,110,111,115,116,117; tile (3,0) lane 0 = 118.
REQ-022 base=0, rows=4, cols=5, stride=5 -> tile (0,3) mask=0x0DB, tile (3,0) mask=0x007, tile (3,3) mask=0x003 with last_tile=1; masked lanes address 0.
REQ-023 wr_mode=1 walk, advance held low 5 cycles then high -> outputs stable, lane_we=0 while held, lane_we=lane_mask on the accept cycle; start pulsed mid-walk has no effect.
REQ-024 reset asserted while on the second tile -> next cycle tile_valid=0, busy=0, done=0; a new start restarts at (0,0).
REQ-025 rows=0, start -> done=1 on the next cycle, tile_valid never 1; ADDR_WIDTH=4, base=14, rows=1, cols=3, stride=1 -> lanes 14,15,0 (wrap).
